// File: rtl/bus_pkg.sv
// Shared types and widths for the single-master bus fabric and its address decoder.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERROR  = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [MASK_W-1:0] write_mask;
        logic [WORD_W-1:0] write_value;
    } req_t;

    // Width of the ACCESS watchdog counter; never below one bit so a disabled timeout still elaborates.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bus_decode.sv
// Combinational address decoder: one-hot select of the lowest-index window that matches.
module bus_decode
    import bus_pkg::*;
#(
    parameter int                       SLAVES     = 4,
    parameter logic [SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h0003_0000, 32'h0002_0000,
                                                      32'h0001_0000, 32'h0000_0000},
    parameter logic [SLAVES*ADDR_W-1:0] SLAVE_MASK = {SLAVES{32'hFFFF_0000}}
) (
    input  logic [ADDR_W-1:0] address,
    output logic [SLAVES-1:0] sel,
    output logic              hit
);

    // Walk from the highest index down so the lowest-index match is the one left standing.
    always_comb begin
        sel = '0;
        for (int k = SLAVES - 1; k >= 0; k--) begin
            if ((address & SLAVE_MASK[k*ADDR_W +: ADDR_W]) == SLAVE_BASE[k*ADDR_W +: ADDR_W]) begin
                sel    = '0;
                sel[k] = 1'b1;
            end
        end
        hit = |sel;
    end

endmodule

// File: rtl/bus_fabric.sv
// Single-master, multi-slave word bus: decode, wait for slave ready or watchdog, return one response strobe.
// Handshake: master holds valid_in and request fields until ready_out; ready_out is a one-cycle strobe qualified by error_out.
module bus_fabric
    import bus_pkg::*;
#(
    parameter int                       SLAVES     = 4,
    parameter logic [SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h0003_0000, 32'h0002_0000,
                                                      32'h0001_0000, 32'h0000_0000},
    parameter logic [SLAVES*ADDR_W-1:0] SLAVE_MASK = {SLAVES{32'hFFFF_0000}},
    parameter int                       TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     valid_in,
    input  logic [ADDR_W-1:0]        address_in,
    input  logic [MASK_W-1:0]        write_mask_in,
    input  logic [WORD_W-1:0]        write_value_in,
    output logic                     ready_out,
    output logic [WORD_W-1:0]        read_value_out,
    output logic                     error_out,
    output logic [ADDR_W-1:0]        fault_address_out,
    output logic [SLAVES-1:0]        sel_out,
    output logic [ADDR_W-1:0]        address_out,
    output logic [MASK_W-1:0]        write_mask_out,
    output logic [WORD_W-1:0]        write_value_out,
    input  logic [SLAVES-1:0]        ready_in,
    input  logic [SLAVES*WORD_W-1:0] read_value_in
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] ACCESS = ST_ACCESS;
    localparam logic [1:0] ERROR  = ST_ERROR;
    localparam logic [1:0] RESP   = ST_RESP;

    localparam int               CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state;
    req_t              req;
    logic [CNT_W-1:0]  count;
    logic [SLAVES-1:0] dec_sel;
    logic              dec_hit;
    logic              slave_ready;
    logic [WORD_W-1:0] slave_data;
    logic              timeout_hit;

    bus_decode #(
        .SLAVES     (SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .address (address_in),
        .sel     (dec_sel),
        .hit     (dec_hit)
    );

    assign address_out     = req.address;
    assign write_mask_out  = req.write_mask;
    assign write_value_out = req.write_value;

    // sel_out is one-hot during ACCESS, so an AND-OR mux picks the selected slave's data and ready.
    always_comb begin
        slave_data = '0;
        for (int k = 0; k < SLAVES; k++) begin
            if (sel_out[k]) begin
                slave_data = slave_data | read_value_in[k*WORD_W +: WORD_W];
            end
        end
        slave_ready = |(ready_in & sel_out);
        timeout_hit = (TIMEOUT != 0) && (count == CNT_TO);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            req               <= '0;
            count             <= '0;
            sel_out           <= '0;
            ready_out         <= 1'b0;
            error_out         <= 1'b0;
            read_value_out    <= '0;
            fault_address_out <= '0;
        end else begin
            ready_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        req.address     <= address_in;
                        req.write_mask  <= write_mask_in;
                        req.write_value <= write_value_in;
                        count           <= '0;
                        if (dec_hit) begin
                            sel_out <= dec_sel;
                            state   <= ACCESS;
                        end else begin
                            state   <= ERROR;
                        end
                    end
                end
                ACCESS: begin
                    // A slave ready in the same cycle as the watchdog expiry still completes normally.
                    if (slave_ready) begin
                        read_value_out <= slave_data;
                        error_out      <= 1'b0;
                        ready_out      <= 1'b1;
                        sel_out        <= '0;
                        state          <= RESP;
                    end else if (timeout_hit) begin
                        read_value_out    <= '0;
                        error_out         <= 1'b1;
                        fault_address_out <= req.address;
                        ready_out         <= 1'b1;
                        sel_out           <= '0;
                        state             <= RESP;
                    end else if (count != CNT_MAX) begin
                        count <= count + CNT_W'(1);
                    end
                end
                ERROR: begin
                    read_value_out    <= '0;
                    error_out         <= 1'b1;
                    fault_address_out <= req.address;
                    ready_out         <= 1'b1;
                    state             <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
